gfx_elim_sequencer: RTL and testbench
=====================================

Name: gfx_elim_sequencer

Overview:
- Column controller for the single-pass GF(2^m) systemizer.
- Accepts a row-serial element stream plus per-row pivot information and drives the op code, factor, start and data lanes of the processor_B cell chain for one elimination column.
- Inserts safe bubbles on input starvation, appends a flush row to drain the held pivot row, and reports done or fail.

Parameters:
- WIDTH, 8, field element width in bits (GF(2^WIDTH)).
- ROW_LEN, 16, elements per row; must be >= 2.
- N_ROWS, 8, rows per pass; must be >= 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- go  in  1  start-of-pass pulse; ignored unless in IDLE
- in_valid  in  1  input element valid
- in_ready  out  1  input element accepted when in_valid & in_ready
- in_data  in  WIDTH  input element
- in_lead_nz  in  1  row leading element nonzero; sampled on the first accepted element of each row
- in_fac  in  WIDTH  row factor; sampled on the first accepted element of each row
- pe_data  out  WIDTH  data to processor chain
- pe_fac  out  WIDTH  factor to processor chain; held constant for the whole row
- pe_op  out  2  op code: 00 pass, 01 swap, 10 eliminate, 11 inv-add
- pe_start  out  1  high on the first element of each issued row, including the flush row
- pe_valid  out  1  qualifies pe_data; low on bubbles
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at end of pass
- fail  out  1  sticky; set at end of pass if no pivot was captured; cleared by go or reset

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE, all counters 0, pivot_pending=1. Outputs: in_ready=0, pe_data=0, pe_fac=0, pe_op=00, pe_start=0, pe_valid=0, busy=0, done=0, fail=0.
- Reset asserted mid-pass aborts immediately. No flush is issued and done is not pulsed.
- States:
  - IDLE: go -> RUN. Clears the element counter (ecnt), the row counter (rcnt) and fail; sets pivot_pending=1.
  - RUN: in_ready=1.
    - On an accepted element: ecnt increments.
    - On ecnt==ROW_LEN-1: ecnt wraps to 0 and rcnt increments.
    - On the last element of row N_ROWS-1: -> FLUSH.
  - FLUSH: in_ready=0. Issues ROW_LEN elements with pe_data=0, pe_op=01, pe_fac=0 and pe_valid=1; pe_start=1 on the first. Then -> DONE.
  - DONE: for one cycle, done=1 and fail=pivot_pending. Then -> IDLE.
- All pe_* outputs are registered. Latency from an accepted input element to its pe_* beat is exactly 1 cycle.
- Op selection is decided on the first element of a row (row_op), latched, and held for all ROW_LEN beats:
  - pivot_pending & in_lead_nz -> 11; pivot_pending is cleared.
  - pivot_pending & !in_lead_nz -> 01.
  - !pivot_pending -> 10.
- pe_fac takes in_fac on the first element of a row and holds it until the next row start.
- Bubble (RUN with in_valid=0): the next cycle drives pe_valid=0, pe_op=00, pe_data=0 and pe_start=0; pe_fac holds. Op 00 leaves the cell registers unchanged, so bubbles are transparent. ecnt does not advance.
- Bubbles are allowed mid-row; the resumed row continues with the same row_op.
- A second pivot candidate after capture is treated as eliminate (10).
- go while busy is ignored.
- No back-pressure from the chain; the chain consumes every beat.
- Row wrap: ecnt==ROW_LEN-1 and rcnt==N_ROWS-1 in the same cycle is the transition to FLUSH. No extra idle cycle is inserted between the last input beat and the first flush beat.

Optional Feature:
- Macro: GFX_SEQ_STALL_CNT_EN.
- Defined: adds output stall_cnt [15:0].
  - Counts RUN-state cycles with in_valid=0.
  - Saturates at 16'hFFFF.
  - Cleared on go and on reset.
  - Holds its value after DONE.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- WIDTH=8, ROW_LEN=4, N_ROWS=3; go; 12 back-to-back elements; row 0 lead_nz=1.
  -> pe_op sequence 11x4, 10x4, 10x4, then flush 01x4 with pe_data=0.
  -> pe_start on beats 0, 4, 8, 12.
  -> done pulses 1 cycle after the last flush beat; fail=0.
- Lead_nz pattern 0,0,1.
  -> ops 01, 01, 11, then flush 01; fail=0.
- All lead_nz=0.
  -> ops 01, 01, 01, flush; done=1 with fail=1. fail stays 1 until the next go.
- Row 1 with in_fac=8'hA5 and in_valid dropped for 3 cycles after element 1.
  -> 3 beats with pe_valid=0, pe_op=00, pe_fac=8'hA5.
  -> The row resumes with op 10; total output beats = 16.
- rst_n low for 1 cycle during row 1.
  -> All outputs 0 next cycle, state IDLE, no done.
  -> A following go restarts from row 0 with pivot_pending=1.
- With GFX_SEQ_STALL_CNT_EN: 5 starved RUN cycles.
  -> stall_cnt=5 at done; go clears it to 0.

Source files
------------

// File: rtl/gfx_elim_sequencer.sv
// gfx_elim_sequencer: column controller for the single-pass GF(2^m) systemizer.
// Turns a row-serial element stream into op/factor/start/data beats for the
// processor_B cell chain, bubbles on starvation, appends a flush row to drain
// the held pivot row, and reports done/fail.
// Optional build macro GFX_SEQ_STALL_CNT_EN adds the stall_cnt output.
module gfx_elim_sequencer #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned ROW_LEN = 16,
  parameter int unsigned N_ROWS  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_lead_nz,
  input  logic [WIDTH-1:0] in_fac,
  output logic [WIDTH-1:0] pe_data,
  output logic [WIDTH-1:0] pe_fac,
  output logic [1:0]       pe_op,
  output logic             pe_start,
  output logic             pe_valid,
  output logic             busy,
  output logic             done,
`ifdef GFX_SEQ_STALL_CNT_EN
  output logic             fail,
  output logic [15:0]      stall_cnt
`else
  output logic             fail
`endif
);

  localparam int unsigned EW = $clog2(ROW_LEN);
  localparam int unsigned RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

  localparam logic [1:0] OP_PASS   = 2'b00;
  localparam logic [1:0] OP_SWAP   = 2'b01;
  localparam logic [1:0] OP_ELIM   = 2'b10;
  localparam logic [1:0] OP_INVADD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [EW-1:0]    r_ecnt;
  logic [RW-1:0]    r_rcnt;
  logic             r_pivot_pending;
  logic [1:0]       r_row_op;
  logic             r_in_ready;
  logic [WIDTH-1:0] r_pe_data;
  logic [WIDTH-1:0] r_pe_fac;
  logic [1:0]       r_pe_op;
  logic             r_pe_start;
  logic             r_pe_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_fail;
`ifdef GFX_SEQ_STALL_CNT_EN
  logic [15:0]      r_stall_cnt;
`endif

  logic       w_row_first;
  logic       w_row_last;
  logic       w_pass_last;
  logic [1:0] w_new_op;

  assign w_row_first = (r_ecnt == '0);
  assign w_row_last  = (r_ecnt == EW'(ROW_LEN - 1));
  assign w_pass_last = w_row_last && (r_rcnt == RW'(N_ROWS - 1));

  // Row op chosen from the pivot state and this row's leading element
  always_comb begin
    w_new_op = OP_ELIM;
    if (r_pivot_pending) begin
      w_new_op = in_lead_nz ? OP_INVADD : OP_SWAP;
    end
  end

  // Sequencer FSM with all chain-facing outputs registered (1-cycle latency)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_ecnt          <= '0;
      r_rcnt          <= '0;
      r_pivot_pending <= 1'b1;
      r_row_op        <= OP_PASS;
      r_in_ready      <= 1'b0;
      r_pe_data       <= '0;
      r_pe_fac        <= '0;
      r_pe_op         <= OP_PASS;
      r_pe_start      <= 1'b0;
      r_pe_valid      <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_fail          <= 1'b0;
`ifdef GFX_SEQ_STALL_CNT_EN
      r_stall_cnt     <= '0;
`endif
    end else begin
      // Idle/bubble beat unless a state below issues a real one; pe_fac holds
      r_pe_valid <= 1'b0;
      r_pe_start <= 1'b0;
      r_pe_op    <= OP_PASS;
      r_pe_data  <= '0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (go) begin
            r_state         <= S_RUN;
            r_ecnt          <= '0;
            r_rcnt          <= '0;
            r_fail          <= 1'b0;
            r_pivot_pending <= 1'b1;
            r_in_ready      <= 1'b1;
            r_busy          <= 1'b1;
`ifdef GFX_SEQ_STALL_CNT_EN
            r_stall_cnt     <= '0;
`endif
          end
        end
        S_RUN: begin
          if (in_valid) begin
            r_pe_valid <= 1'b1;
            r_pe_data  <= in_data;
            r_pe_start <= w_row_first;
            if (w_row_first) begin
              r_pe_op  <= w_new_op;
              r_row_op <= w_new_op;
              r_pe_fac <= in_fac;
              if (r_pivot_pending && in_lead_nz) begin
                r_pivot_pending <= 1'b0;
              end
            end else begin
              r_pe_op <= r_row_op;
            end
            if (w_row_last) begin
              r_ecnt <= '0;
              if (w_pass_last) begin
                r_state    <= S_FLUSH;
                r_in_ready <= 1'b0;
              end else begin
                r_rcnt <= r_rcnt + RW'(1);
              end
            end else begin
              r_ecnt <= r_ecnt + EW'(1);
            end
          end else begin
`ifdef GFX_SEQ_STALL_CNT_EN
            if (r_stall_cnt != 16'hFFFF) begin
              r_stall_cnt <= r_stall_cnt + 16'd1;
            end
`endif
          end
        end
        S_FLUSH: begin
          r_pe_valid <= 1'b1;
          r_pe_op    <= OP_SWAP;
          r_pe_fac   <= '0;
          r_pe_start <= w_row_first;
          if (w_row_last) begin
            r_ecnt  <= '0;
            r_state <= S_DONE;
          end else begin
            r_ecnt <= r_ecnt + EW'(1);
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_fail  <= r_pivot_pending;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign pe_data   = r_pe_data;
  assign pe_fac    = r_pe_fac;
  assign pe_op     = r_pe_op;
  assign pe_start  = r_pe_start;
  assign pe_valid  = r_pe_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign fail      = r_fail;
`ifdef GFX_SEQ_STALL_CNT_EN
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_gfx_elim_sequencer.sv
// Self-checking bench for gfx_elim_sequencer (WIDTH=8, ROW_LEN=4, N_ROWS=3).
// Expected streams are built per pass from the row list and the pivot rule.
module tb_gfx_elim_sequencer;

  localparam int unsigned W  = 8;
  localparam int unsigned RL = 4;
  localparam int unsigned NR = 3;

  logic         clk = 1'b0;
  logic         rst_n, go, in_valid, in_lead_nz;
  logic [W-1:0] in_data, in_fac;
  logic         in_ready;
  logic [W-1:0] pe_data, pe_fac;
  logic [1:0]   pe_op;
  logic         pe_start, pe_valid, busy, done, fail;
`ifdef GFX_SEQ_STALL_CNT_EN
  logic [15:0]  stall_cnt;
`endif

  gfx_elim_sequencer #(.WIDTH(W), .ROW_LEN(RL), .N_ROWS(NR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .go         (go),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_lead_nz (in_lead_nz),
    .in_fac     (in_fac),
    .pe_data    (pe_data),
    .pe_fac     (pe_fac),
    .pe_op      (pe_op),
    .pe_start   (pe_start),
    .pe_valid   (pe_valid),
    .busy       (busy),
    .done       (done),
`ifdef GFX_SEQ_STALL_CNT_EN
    .fail       (fail),
    .stall_cnt  (stall_cnt)
`else
    .fail       (fail)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         l;
    logic [W-1:0] f;
  } slot_t;

  typedef struct {
    logic         valid;
    logic [1:0]   op;
    logic [W-1:0] data;
    logic [W-1:0] fac;
    logic         start;
    logic         done;
    logic         ready;
  } exp_t;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] row_data [NR][RL];
  int           stall_before [NR][RL];
  logic         row_lead [NR];
  logic [W-1:0] row_fac [NR];

  slot_t sq[$];
  exp_t  eq[$];
  logic  exp_fail;
  int    exp_stalls;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Random row contents; stall_pct is the chance of a 1..3 cycle gap before an element
  task automatic rand_rows(input int stall_pct);
    for (int r = 0; r < NR; r++) begin
      row_lead[r] = 1'($urandom_range(0, 1));
      row_fac[r]  = W'($urandom);
      for (int e = 0; e < RL; e++) begin
        row_data[r][e]     = W'($urandom);
        stall_before[r][e] = (int'($urandom_range(0, 99)) < stall_pct) ? int'($urandom_range(1, 3)) : 0;
      end
    end
  endtask

  // Build input slots and the cycle-by-cycle expected output stream for one pass
  task automatic plan_pass();
    logic         pivot;
    logic [1:0]   op;
    logic [W-1:0] cur_fac;
    exp_t         x;
    sq.delete();
    eq.delete();
    pivot      = 1'b1;
    cur_fac    = '0;
    exp_stalls = 0;
    for (int r = 0; r < NR; r++) begin
      if (!pivot)             op = 2'b10;
      else if (row_lead[r])   op = 2'b11;
      else                    op = 2'b01;
      if (pivot && row_lead[r]) pivot = 1'b0;
      for (int e = 0; e < RL; e++) begin
        for (int s = 0; s < stall_before[r][e]; s++) begin
          sq.push_back('{v: 1'b0, d: W'($urandom), l: 1'($urandom_range(0, 1)), f: W'($urandom)});
          eq.push_back('{valid: 1'b0, op: 2'b00, data: '0, fac: cur_fac, start: 1'b0, done: 1'b0, ready: 1'b1});
          exp_stalls++;
        end
        if (e == 0) cur_fac = row_fac[r];
        sq.push_back('{v: 1'b1, d: row_data[r][e], l: (e == 0) ? row_lead[r] : 1'($urandom_range(0, 1)),
                       f: (e == 0) ? row_fac[r] : W'($urandom)});
        eq.push_back('{valid: 1'b1, op: op, data: row_data[r][e], fac: cur_fac, start: (e == 0), done: 1'b0, ready: 1'b1});
      end
    end
    x = eq.pop_back();
    x.ready = 1'b0;
    eq.push_back(x);
    for (int e = 0; e < RL; e++) begin
      eq.push_back('{valid: 1'b1, op: 2'b01, data: '0, fac: '0, start: (e == 0), done: 1'b0, ready: 1'b0});
    end
    eq.push_back('{valid: 1'b0, op: 2'b00, data: '0, fac: '0, start: 1'b0, done: 1'b1, ready: 1'b0});
    exp_fail = pivot;
  endtask

  task automatic drive_slot(input int k, input bit allow_go);
    if (k < sq.size()) begin
      in_valid   = sq[k].v;
      in_data    = sq[k].d;
      in_lead_nz = sq[k].l;
      in_fac     = sq[k].f;
      go         = allow_go && ($urandom_range(0, 7) == 0);
    end else begin
      in_valid   = 1'b0;
      in_data    = W'($urandom);
      in_lead_nz = 1'b0;
      in_fac     = W'($urandom);
      go         = 1'b0;
    end
  endtask

  // Run a planned pass; abort_at >= 0 pulses reset after that stream index is checked
  task automatic run_pass(input int abort_at);
    int beats;
    beats = 0;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    chk("start_ready", 32'(in_ready), 32'd1);
    chk("start_busy",  32'(busy),     32'd1);
    chk("start_fail",  32'(fail),     32'd0);
    chk("start_valid", 32'(pe_valid), 32'd0);
`ifdef GFX_SEQ_STALL_CNT_EN
    chk("start_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    drive_slot(0, 1'b1);
    for (int i = 0; i < eq.size(); i++) begin
      @(posedge clk); #1;
      chk("pe_valid", 32'(pe_valid), 32'(eq[i].valid));
      chk("pe_op",    32'(pe_op),    32'(eq[i].op));
      chk("pe_data",  32'(pe_data),  32'(eq[i].data));
      chk("pe_fac",   32'(pe_fac),   32'(eq[i].fac));
      chk("pe_start", 32'(pe_start), 32'(eq[i].start));
      chk("done",     32'(done),     32'(eq[i].done));
      chk("in_ready", 32'(in_ready), 32'(eq[i].ready));
      chk("busy",     32'(busy),     32'(!eq[i].done));
      chk("fail",     32'(fail),     eq[i].done ? 32'(exp_fail) : 32'd0);
`ifdef GFX_SEQ_STALL_CNT_EN
      if (eq[i].done) chk("stall_cnt_done", 32'(stall_cnt), 32'(exp_stalls));
`endif
      if (pe_valid) beats++;
      if (i == abort_at) begin
        rst_n = 1'b0;
        drive_slot(sq.size(), 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_pe_valid", 32'(pe_valid), 32'd0);
        chk("rst_pe_op",    32'(pe_op),    32'd0);
        chk("rst_pe_data",  32'(pe_data),  32'd0);
        chk("rst_pe_fac",   32'(pe_fac),   32'd0);
        chk("rst_pe_start", 32'(pe_start), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_fail",     32'(fail),     32'd0);
        for (int c = 0; c < RL + 2; c++) begin
          @(posedge clk); #1;
          chk("abort_no_done",  32'(done),     32'd0);
          chk("abort_idle",     32'(busy),     32'd0);
          chk("abort_no_valid", 32'(pe_valid), 32'd0);
        end
        return;
      end
      drive_slot(i + 1, 1'b1);
    end
    chk("beat_count", 32'(beats), 32'(NR * RL + RL));
    @(posedge clk); #1;
    chk("post_done",  32'(done),     32'd0);
    chk("post_busy",  32'(busy),     32'd0);
    chk("post_fail",  32'(fail),     32'(exp_fail));
    chk("post_ready", 32'(in_ready), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; go = 1'b0; in_valid = 1'b0; in_lead_nz = 1'b0;
    in_data = '0; in_fac = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 32'(in_ready), 32'd0);
    chk("reset_data",  32'(pe_data),  32'd0);
    chk("reset_fac",   32'(pe_fac),   32'd0);
    chk("reset_op",    32'(pe_op),    32'd0);
    chk("reset_start", 32'(pe_start), 32'd0);
    chk("reset_valid", 32'(pe_valid), 32'd0);
    chk("reset_busy",  32'(busy),     32'd0);
    chk("reset_done",  32'(done),     32'd0);
    chk("reset_fail",  32'(fail),     32'd0);
`ifdef GFX_SEQ_STALL_CNT_EN
    chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Pivot on row 0, back-to-back
    rand_rows(0);
    row_lead[0] = 1'b1; row_lead[1] = 1'b0; row_lead[2] = 1'b1;
    plan_pass();
    run_pass(-1);

    // Pivot on the last row
    rand_rows(0);
    row_lead[0] = 1'b0; row_lead[1] = 1'b0; row_lead[2] = 1'b1;
    plan_pass();
    run_pass(-1);

    // No pivot: fail, sticky across idle cycles
    rand_rows(0);
    row_lead[0] = 1'b0; row_lead[1] = 1'b0; row_lead[2] = 1'b0;
    plan_pass();
    run_pass(-1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("fail_sticky", 32'(fail), 32'd1);
    end

    // Mid-row starvation with a known row factor
    rand_rows(0);
    row_lead[0] = 1'b1; row_lead[1] = 1'b1; row_lead[2] = 1'b0;
    row_fac[1] = 8'hA5;
    stall_before[1][2] = 3;
    plan_pass();
    run_pass(-1);

    // Reset during row 1, then a clean pass restarting with pivot pending
    rand_rows(0);
    row_lead[0] = 1'b1;
    plan_pass();
    run_pass(RL + 1);
    rand_rows(0);
    row_lead[0] = 1'b0; row_lead[1] = 1'b1; row_lead[2] = 1'b1;
    plan_pass();
    run_pass(-1);

    // Exactly five starved RUN cycles
    rand_rows(0);
    stall_before[0][1] = 2;
    stall_before[2][3] = 3;
    plan_pass();
    run_pass(-1);

    // Randomized passes with random gaps and go pulses while busy
    for (int p = 0; p < 10; p++) begin
      rand_rows(25);
      plan_pass();
      run_pass(-1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
